// File: rtl/hilo_pkg.sv
// hilo_pkg: shared width, op codes and FSM states for the HI/LO multiply controller
package hilo_pkg;
  localparam int XLEN = 32;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MADD  = 6'b011100;
  localparam logic [5:0] OP_MADDU = 6'b011101;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, WB} state_t;
endpackage

// File: rtl/shift_add_step.sv
// shift_add_step: one right-shifting shift-add multiply iteration
module shift_add_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] partial,
  input  logic [W-1:0]   mcand,
  output logic [2*W-1:0] result
);
  logic         mbit;
  logic [W:0]   sum;
  // The low half holds the not-yet-consumed multiplier bits; bit 0 is the current one.
  always_comb begin
    mbit   = partial[0];
    sum    = {1'b0, partial[2*W-1:W]} + (mbit ? {1'b0, mcand} : '0);
    result = {sum, partial[W-1:1]};
  end
endmodule

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: multi-cycle MULT/MULTU/MADD/MADDU unit with HI/LO registers and MFHI/MFLO reads
module hilo_mult_ctrl
  import hilo_pkg::*;
#(
  parameter int XLEN = hilo_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic            illegal,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] rd_data
);
  localparam int CW = $clog2(XLEN);
  state_t            state, state_nx;
  logic [5:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, mcand, a_mag, b_mag;
  logic [2*XLEN-1:0] prod, step;
  logic [CW-1:0]     cnt;
  logic              is_mul, is_mf, accept, q_signed, q_acc, neg;
  shift_add_step #(.W(XLEN)) u_step (
    .partial(prod),
    .mcand  (mcand),
    .result (step)
  );
  always_comb begin
    is_mul   = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU};
    is_mf    = op == OP_MFHI || op == OP_MFLO;
    busy     = state != IDLE;
    accept   = start && is_mul && !busy && !cancel;
    stall    = start && (is_mul || is_mf) && busy;
    illegal  = start && !(is_mul || is_mf);
    rd_data  = (start && !busy && op == OP_MFHI) ? hi :
               (start && !busy && op == OP_MFLO) ? lo : '0;
    q_signed = op_q == OP_MULT || op_q == OP_MADD;
    q_acc    = op_q == OP_MADD || op_q == OP_MADDU;
    // Negating 0x80..0 wraps back to itself, which read as unsigned is exactly 2^(XLEN-1).
    a_mag    = (q_signed && a_q[XLEN-1]) ? -a_q : a_q;
    b_mag    = (q_signed && b_q[XLEN-1]) ? -b_q : b_q;
    neg      = q_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    state_nx = (cancel && busy)  ? IDLE :
               (state == IDLE)   ? (accept ? PREP : IDLE) :
               (state == PREP)   ? RUN :
               (state == RUN)    ? ((cnt == CW'(XLEN - 1)) ? FIX : RUN) :
               (state == FIX)    ? WB : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      prod  <= '0;
      mcand <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nx;
      done  <= state == WB && !cancel;
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (state == PREP) begin
        mcand <= a_mag;
        prod  <= {{XLEN{1'b0}}, b_mag};
        cnt   <= '0;
      end
      if (state == RUN) begin
        prod <= step;
        cnt  <= cnt + 1'b1;
      end
      if (state == FIX && neg) prod <= -prod;
      if (state == WB && !cancel) {hi, lo} <= q_acc ? {hi, lo} + prod : prod;
    end
  end
endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// tb_hilo_mult_ctrl: scenario tasks with a scoreboard of expected {hi,lo} results
module tb_hilo_mult_ctrl;
  import hilo_pkg::*;
  logic        clk = 0, rst_n = 0, start = 0, cancel = 0;
  logic [5:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, stall, illegal;
  logic [31:0] hi, lo, rd_data;
  int          checks = 0, errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model = '0;
  hilo_mult_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .done(done), .stall(stall), .illegal(illegal),
    .hi(hi), .lo(lo), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] calc(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                                       input logic [63:0] cur);
    logic signed [63:0] sx, sy;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    p  = (o == OP_MULT || o == OP_MADD) ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
    return (o == OP_MADD || o == OP_MADDU) ? cur + p : p;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y, input bit commit);
    op = o; a = x; b = y; start = 1;
    tick;
    start = 0;
    if (commit) begin
      model = calc(o, x, y, model);
      exp_q.push_back(model);
    end
  endtask
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      tick;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    tick;
    tick;
    rst_n = 1;
    #1;
    checks++;
    if ({busy, done, stall, illegal, hi, lo, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b stall=%b illegal=%b hi=%h lo=%h rd=%h expected all zero",
               busy, done, stall, illegal, hi, lo, rd_data);
    end
  endtask
  task automatic test_mult;
    logic [5:0]  ops[7]  = '{OP_MULTU, OP_MULT, OP_MULT, OP_MULTU, OP_MADDU, OP_MULT, OP_MADD};
    logic [31:0] as[7]   = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF};
    logic [31:0] bs[7]   = '{32'hFFFFFFFF, 32'h7, 32'h80000000, 32'h1, 32'h1, 32'h0, 32'h1};
    logic [63:0] lit[7]  = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000,
                             64'h00000000_FFFFFFFF, 64'h00000001_00000000, 64'h0, 64'hFFFFFFFF_FFFFFFFF};
    logic [5:0]  rops[4] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU};
    logic [63:0] e;
    int lat;
    for (int i = 0; i < 13; i++) begin
      if (i < 7) issue(ops[i], as[i], bs[i], 1);
      else issue(rops[$urandom_range(3)], $urandom, $urandom, 1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept op%0d got %b expected 1", i, busy); end
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat != 35) begin errors++; $display("FAIL done_latency op%0d got %0d expected 35", i, lat); end
      checks++;
      if ({hi, lo} !== e) begin errors++; $display("FAIL hilo op%0d got %h_%h expected %h", i, hi, lo, e); end
      if (i < 7) begin
        checks++;
        if ({hi, lo} !== lit[i]) begin errors++; $display("FAIL hilo_const op%0d got %h_%h expected %h", i, hi, lo, lit[i]); end
      end
      tick;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_pulse op%0d got %b expected 0", i, done); end
    end
  endtask
  task automatic test_mf_stall;
    logic [63:0] e;
    bit got = 0;
    op = OP_MFHI; start = 1;
    #1;
    checks++;
    if (rd_data !== model[63:32] || stall !== 1'b0) begin
      errors++; $display("FAIL mfhi_idle got rd=%h stall=%b expected rd=%h stall=0", rd_data, stall, model[63:32]);
    end
    op = OP_MFLO;
    #1;
    checks++;
    if (rd_data !== model[31:0] || stall !== 1'b0) begin
      errors++; $display("FAIL mflo_idle got rd=%h stall=%b expected rd=%h stall=0", rd_data, stall, model[31:0]);
    end
    tick;
    start = 0;
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== model) begin
      errors++; $display("FAIL mf_no_effect got busy=%b hilo=%h_%h expected busy=0 hilo=%h", busy, hi, lo, model);
    end
    issue(OP_MULT, 32'd12345, 32'hFFFFFFF7, 1);
    tick;
    tick;
    op = OP_MFLO; start = 1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (done) begin
        got = 1;
        e = exp_q.pop_front();
        checks++;
        if (stall !== 1'b0 || rd_data !== e[31:0]) begin
          errors++; $display("FAIL mflo_retry got stall=%b rd=%h expected stall=0 rd=%h", stall, rd_data, e[31:0]);
        end
        checks++;
        if ({hi, lo} !== e) begin errors++; $display("FAIL mflo_hilo got %h_%h expected %h", hi, lo, e); end
        break;
      end
      checks++;
      if (stall !== 1'b1 || rd_data !== 32'h0) begin
        errors++; $display("FAIL mflo_stall cycle%0d got stall=%b rd=%h expected stall=1 rd=0", n, stall, rd_data);
      end
      tick;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL mflo_timeout got no done expected done"); end
    tick;
    start = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mflo_no_accept got busy=%b expected 0", busy); end
  endtask
  task automatic test_cancel;
    int seen = 0;
    issue(OP_MULT, 32'd7, 32'd9, 0);
    repeat (9) tick;
    cancel = 1;
    tick;
    cancel = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b expected 0", busy); end
    repeat (40) begin tick; seen += int'(done); end
    checks++;
    if (seen != 0 || {hi, lo} !== model) begin
      errors++; $display("FAIL cancel_effect got dones=%0d hilo=%h_%h expected 0 and %h", seen, hi, lo, model);
    end
    cancel = 1; op = OP_MULT; start = 1;
    tick;
    cancel = 0; start = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_block got busy=%b expected 0", busy); end
    issue(OP_MULTU, 32'd3, 32'd5, 0);
    repeat (33) tick;
    cancel = 1;
    tick;
    cancel = 0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== model) begin
      errors++; $display("FAIL cancel_wb got done=%b busy=%b hilo=%h_%h expected 0 0 %h", done, busy, hi, lo, model);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL cancel_wb_late got done=%b expected 0", done); end
    issue(OP_MULTU, 32'hDEAD, 32'hBEEF, 0);
    repeat (18) tick;
    rst_n = 0; cancel = 1; op = OP_MULT; start = 1;
    tick;
    rst_n = 1; cancel = 0; start = 0;
    model = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_midop got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    seen = 0;
    repeat (40) begin tick; seen += int'(done); end
    checks++;
    if (seen != 0 || {hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_no_done got dones=%0d hilo=%h_%h expected 0 and 0", seen, hi, lo);
    end
  endtask
  task automatic test_illegal;
    logic [63:0] e;
    int lat;
    op = 6'b100000; start = 1;
    #1;
    checks++;
    if (illegal !== 1'b1 || stall !== 1'b0 || rd_data !== 32'h0) begin
      errors++; $display("FAIL illegal_idle got illegal=%b stall=%b rd=%h expected 1 0 0", illegal, stall, rd_data);
    end
    tick;
    start = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got %b expected 0", busy); end
    issue(OP_MADDU, 32'h1234, 32'h10, 1);
    op = 6'b111111; start = 1;
    #1;
    checks++;
    if (illegal !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL illegal_while_busy got illegal=%b stall=%b expected 1 0", illegal, stall);
    end
    tick;
    start = 0;
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat != 34 || {hi, lo} !== e) begin
      errors++; $display("FAIL illegal_op_result got lat=%0d hilo=%h_%h expected 34 %h", lat, hi, lo, e);
    end
  endtask
  task automatic test_back_to_back;
    logic [63:0] e;
    int lat;
    issue(OP_MULT, 32'h80000000, 32'h3, 1);
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat != 35 || {hi, lo} !== e) begin
      errors++; $display("FAIL b2b_first got lat=%0d hilo=%h_%h expected 35 %h", lat, hi, lo, e);
    end
    issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b expected 1", busy); end
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat != 35 || {hi, lo} !== e) begin
      errors++; $display("FAIL b2b_second got lat=%0d hilo=%h_%h expected 35 %h", lat, hi, lo, e);
    end
  endtask
  initial begin
    test_reset;
    test_mult;
    test_mf_stall;
    test_cancel;
    test_illegal;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
